// File: rtl/pipe_pkg.sv
// pipe_pkg: shared definitions for the execute stage of the 5-stage pipeline.
//   - ALU operation codes carried in ID_EX_ALUOp
//   - forwarding-unit select codes for ForwardA/ForwardB
//   - state encoding of the sequential multiplier
//   - default datapath width
package pipe_pkg;

  localparam int DEFAULT_DATA_W = 32;

  localparam logic [3:0] ALU_ADD  = 4'h0;
  localparam logic [3:0] ALU_SUB  = 4'h1;
  localparam logic [3:0] ALU_AND  = 4'h2;
  localparam logic [3:0] ALU_OR   = 4'h3;
  localparam logic [3:0] ALU_XOR  = 4'h4;
  localparam logic [3:0] ALU_NOR  = 4'h5;
  localparam logic [3:0] ALU_SLT  = 4'h6;
  localparam logic [3:0] ALU_SLTU = 4'h7;
  localparam logic [3:0] ALU_SLL  = 4'h8;
  localparam logic [3:0] ALU_SRL  = 4'h9;
  localparam logic [3:0] ALU_SRA  = 4'hA;
  localparam logic [3:0] ALU_LUI  = 4'hB;
  localparam logic [3:0] ALU_MUL  = 4'hC;

  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_WB   = 2'b01;
  localparam logic [1:0] FWD_MEM  = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } mul_state_e;

endpackage

// File: rtl/ex_stage_seq_multiplier.sv
// seq_multiplier: iterative shift-add multiplier used by the execute stage.
// Retires MUL_BITS_PER_CYCLE multiplier bits per clock; MUL_BITS_PER_CYCLE
// must divide DATA_W.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   flush        abandon any operation in progress, return to IDLE
//   start        a valid MUL sits in EX (only sampled in IDLE)
//   op_a, op_b   forwarded operands, captured once on the start edge
//   stall        front-end hold request (combinational in the start cycle)
//   busy         operation in progress (BUSY state)
//   done         product is ready this cycle (DONE state)
//   product      low DATA_W bits of op_a*op_b, valid while done=1
module seq_multiplier
  import pipe_pkg::*;
#(
  parameter int DATA_W             = DEFAULT_DATA_W,
  parameter int MUL_BITS_PER_CYCLE = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              start,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  output logic              stall,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] product
);

  localparam int MUL_CYCLES = DATA_W / MUL_BITS_PER_CYCLE;
  localparam int CNT_W      = $clog2(MUL_CYCLES + 1);

  mul_state_e        state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] mcand_q, mcand_d;
  logic [DATA_W-1:0] mplier_q, mplier_d;
  logic [DATA_W-1:0] acc_q, acc_d;

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d  = op_a;
          mplier_d = op_b;
          acc_d    = '0;
          count_d  = CNT_W'(MUL_CYCLES);
          state_d  = BUSY;
        end
      end
      BUSY: begin
        // Partial product of the low multiplier chunk; the multiplicand
        // moves up by the same amount so the next chunk lines up.
        acc_d    = acc_q + mcand_q * DATA_W'(mplier_q[MUL_BITS_PER_CYCLE-1:0]);
        mcand_d  = mcand_q << MUL_BITS_PER_CYCLE;
        mplier_d = mplier_q >> MUL_BITS_PER_CYCLE;
        count_d  = count_q - CNT_W'(1);
        if (count_q == CNT_W'(1)) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      count_q  <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
    end
  end

  // Stall is gated by rst_n so a MUL waiting in ID/EX cannot hold the
  // front end while the pipeline is in reset.
  assign stall   = rst_n && !flush && (((state_q == IDLE) && start) || (state_q == BUSY));
  assign busy    = (state_q == BUSY);
  assign done    = (state_q == DONE);
  assign product = acc_q;

endmodule

// File: rtl/ex_stage.sv
// ex_stage: execute stage of the 5-stage pipeline.
// Selects forwarded ALU operands, computes single-cycle ALU results or runs
// the sequential multiplier, and owns the EX/MEM pipeline register.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   Flush                kill the instruction in EX (highest priority)
//   ID_EX_*              instruction fields and controls from ID/EX
//   ForwardA/ForwardB    operand selects from the forwarding unit
//   WB_WriteData         write-back value from MEM/WB
//   EX_Stall             hold PC, IF/ID and ID/EX during a multiply
//   EX_MEM_*             registered result, store data, Rd and controls
module ex_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W             = DEFAULT_DATA_W,
  parameter int MUL_BITS_PER_CYCLE = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              Flush,
  input  logic              ID_EX_Valid,
  input  logic [DATA_W-1:0] ID_EX_ReadData1,
  input  logic [DATA_W-1:0] ID_EX_ReadData2,
  input  logic [DATA_W-1:0] ID_EX_Imm,
  input  logic              ID_EX_ALUSrc,
  input  logic [3:0]        ID_EX_ALUOp,
  input  logic [4:0]        ID_EX_RegisterRd,
  input  logic              ID_EX_RegWrite,
  input  logic              ID_EX_MemRead,
  input  logic              ID_EX_MemWrite,
  input  logic              ID_EX_MemtoReg,
  input  logic [1:0]        ForwardA,
  input  logic [1:0]        ForwardB,
  input  logic [DATA_W-1:0] WB_WriteData,
  output logic              EX_Stall,
  output logic [DATA_W-1:0] EX_MEM_ALUResult,
  output logic [DATA_W-1:0] EX_MEM_WriteData,
  output logic [4:0]        EX_MEM_RegisterRd,
  output logic              EX_MEM_RegWrite,
  output logic              EX_MEM_MemRead,
  output logic              EX_MEM_MemWrite,
  output logic              EX_MEM_MemtoReg
);

  logic [DATA_W-1:0] fwd_a, fwd_b, op_b, alu_result, mul_product;
  logic              mul_start, mul_busy, mul_done, load_alu, load_mul;

  logic [DATA_W-1:0] alu_result_q, alu_result_d;
  logic [DATA_W-1:0] write_data_q, write_data_d;
  logic [4:0]        rd_q, rd_d;
  logic              reg_write_q, reg_write_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic              mem_to_reg_q, mem_to_reg_d;

  // Select code 11 falls through to the ID/EX value.
  always_comb begin
    fwd_a = ID_EX_ReadData1;
    fwd_b = ID_EX_ReadData2;
    case (ForwardA)
      FWD_MEM: fwd_a = alu_result_q;
      FWD_WB:  fwd_a = WB_WriteData;
      default: ;
    endcase
    case (ForwardB)
      FWD_MEM: fwd_b = alu_result_q;
      FWD_WB:  fwd_b = WB_WriteData;
      default: ;
    endcase
  end

  assign op_b = ID_EX_ALUSrc ? ID_EX_Imm : fwd_b;

  always_comb begin
    alu_result = '0;
    case (ID_EX_ALUOp)
      ALU_ADD:  alu_result = fwd_a + op_b;
      ALU_SUB:  alu_result = fwd_a - op_b;
      ALU_AND:  alu_result = fwd_a & op_b;
      ALU_OR:   alu_result = fwd_a | op_b;
      ALU_XOR:  alu_result = fwd_a ^ op_b;
      ALU_NOR:  alu_result = ~(fwd_a | op_b);
      ALU_SLT:  alu_result = {{(DATA_W-1){1'b0}}, ($signed(fwd_a) < $signed(op_b))};
      ALU_SLTU: alu_result = {{(DATA_W-1){1'b0}}, (fwd_a < op_b)};
      ALU_SLL:  alu_result = fwd_a << op_b[4:0];
      ALU_SRL:  alu_result = fwd_a >> op_b[4:0];
      ALU_SRA:  alu_result = $signed(fwd_a) >>> op_b[4:0];
      ALU_LUI:  alu_result = DATA_W'({op_b[15:0], 16'h0000});
      default:  alu_result = '0;
    endcase
  end

  assign mul_start = ID_EX_Valid && (ID_EX_ALUOp == ALU_MUL);

  seq_multiplier #(
    .DATA_W             (DATA_W),
    .MUL_BITS_PER_CYCLE (MUL_BITS_PER_CYCLE)
  ) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (Flush),
    .start   (mul_start),
    .op_a    (fwd_a),
    .op_b    (op_b),
    .stall   (EX_Stall),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

  // Anything that is not a finished MUL or a valid single-cycle op in an idle
  // multiplier loads a bubble; bubble data fields keep their old value.
  assign load_mul = !Flush && mul_done;
  assign load_alu = !Flush && ID_EX_Valid && !mul_busy && !mul_done &&
                    (ID_EX_ALUOp != ALU_MUL);

  always_comb begin
    alu_result_d = alu_result_q;
    write_data_d = write_data_q;
    rd_d         = '0;
    reg_write_d  = 1'b0;
    mem_read_d   = 1'b0;
    mem_write_d  = 1'b0;
    mem_to_reg_d = 1'b0;
    if (load_alu || load_mul) begin
      alu_result_d = load_mul ? mul_product : alu_result;
      write_data_d = fwd_b;
      rd_d         = ID_EX_RegisterRd;
      reg_write_d  = ID_EX_RegWrite;
      mem_read_d   = ID_EX_MemRead;
      mem_write_d  = ID_EX_MemWrite;
      mem_to_reg_d = ID_EX_MemtoReg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_result_q <= '0;
      write_data_q <= '0;
      rd_q         <= '0;
      reg_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
    end else begin
      alu_result_q <= alu_result_d;
      write_data_q <= write_data_d;
      rd_q         <= rd_d;
      reg_write_q  <= reg_write_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      mem_to_reg_q <= mem_to_reg_d;
    end
  end

  assign EX_MEM_ALUResult  = alu_result_q;
  assign EX_MEM_WriteData  = write_data_q;
  assign EX_MEM_RegisterRd = rd_q;
  assign EX_MEM_RegWrite   = reg_write_q;
  assign EX_MEM_MemRead    = mem_read_q;
  assign EX_MEM_MemWrite   = mem_write_q;
  assign EX_MEM_MemtoReg   = mem_to_reg_q;

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: self-checking bench for ex_stage (DATA_W=32, 1 bit per cycle).
// A table of directed ALU/forwarding vectors, hand-written multiply, flush and
// reset sequences, then random instructions checked against a reference
// model of the EX/MEM register kept in plain arithmetic.
module tb_ex_stage;
  import pipe_pkg::*;

  localparam int MUL_CYCLES = 32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        Flush;
  logic        ID_EX_Valid;
  logic [31:0] ID_EX_ReadData1, ID_EX_ReadData2, ID_EX_Imm;
  logic        ID_EX_ALUSrc;
  logic [3:0]  ID_EX_ALUOp;
  logic [4:0]  ID_EX_RegisterRd;
  logic        ID_EX_RegWrite, ID_EX_MemRead, ID_EX_MemWrite, ID_EX_MemtoReg;
  logic [1:0]  ForwardA, ForwardB;
  logic [31:0] WB_WriteData;
  logic        EX_Stall;
  logic [31:0] EX_MEM_ALUResult, EX_MEM_WriteData;
  logic [4:0]  EX_MEM_RegisterRd;
  logic        EX_MEM_RegWrite, EX_MEM_MemRead, EX_MEM_MemWrite, EX_MEM_MemtoReg;

  int checks   = 0;
  int failures = 0;

  // Expected EX/MEM register contents.
  logic [31:0] exp_result, exp_wdata;
  logic [4:0]  exp_rd;
  logic        exp_rw, exp_mr, exp_mw, exp_m2r;

  typedef struct {
    logic        valid;
    logic [3:0]  op;
    logic [31:0] a, b, imm;
    logic        alusrc;
    logic [1:0]  fa, fb;
    logic [31:0] wb;
    logic        mw;
    logic [31:0] exp_res, exp_wd;
  } vec_t;

  vec_t vecs[18];

  always #5 clk = ~clk;

  ex_stage dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .Flush             (Flush),
    .ID_EX_Valid       (ID_EX_Valid),
    .ID_EX_ReadData1   (ID_EX_ReadData1),
    .ID_EX_ReadData2   (ID_EX_ReadData2),
    .ID_EX_Imm         (ID_EX_Imm),
    .ID_EX_ALUSrc      (ID_EX_ALUSrc),
    .ID_EX_ALUOp       (ID_EX_ALUOp),
    .ID_EX_RegisterRd  (ID_EX_RegisterRd),
    .ID_EX_RegWrite    (ID_EX_RegWrite),
    .ID_EX_MemRead     (ID_EX_MemRead),
    .ID_EX_MemWrite    (ID_EX_MemWrite),
    .ID_EX_MemtoReg    (ID_EX_MemtoReg),
    .ForwardA          (ForwardA),
    .ForwardB          (ForwardB),
    .WB_WriteData      (WB_WriteData),
    .EX_Stall          (EX_Stall),
    .EX_MEM_ALUResult  (EX_MEM_ALUResult),
    .EX_MEM_WriteData  (EX_MEM_WriteData),
    .EX_MEM_RegisterRd (EX_MEM_RegisterRd),
    .EX_MEM_RegWrite   (EX_MEM_RegWrite),
    .EX_MEM_MemRead    (EX_MEM_MemRead),
    .EX_MEM_MemWrite   (EX_MEM_MemWrite),
    .EX_MEM_MemtoReg   (EX_MEM_MemtoReg)
  );

  // Reference ALU written directly from the operation definitions.
  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int unsigned sh;
    longint unsigned prod;
    sh = int'(b % 32);
    case (op)
      4'h0: return a + b;
      4'h1: return a - b;
      4'h2: return a & b;
      4'h3: return a | b;
      4'h4: return a ^ b;
      4'h5: return ~(a | b);
      4'h6: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      4'h7: return (a < b) ? 32'd1 : 32'd0;
      4'h8: return 32'(longint'(a) * (longint'(1) << sh));
      4'h9: return a / (32'd1 << sh);
      4'hA: return a[31] ? ~((~a) / (32'd1 << sh)) : a / (32'd1 << sh);
      4'hB: return (b % 32'h10000) * 32'h10000;
      4'hC: begin
        prod = longint'(a) * longint'(b);
        return prod[31:0];
      end
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] fwd_value(input logic [1:0] sel, input logic [31:0] id_val,
                                            input logic [31:0] mem_val, input logic [31:0] wb_val);
    if (sel == 2'b10) return mem_val;
    if (sel == 2'b01) return wb_val;
    return id_val;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  // Drive every ID/EX-side input in one go.
  task automatic applyStimulus(input logic valid, input logic [3:0] op, input logic [31:0] rs,
                               input logic [31:0] rt, input logic [31:0] imm, input logic alusrc,
                               input logic [1:0] fa, input logic [1:0] fb, input logic [31:0] wb,
                               input logic [4:0] rd, input logic rw, input logic mr,
                               input logic mw, input logic m2r, input logic flush);
    ID_EX_Valid      = valid;
    ID_EX_ALUOp      = op;
    ID_EX_ReadData1  = rs;
    ID_EX_ReadData2  = rt;
    ID_EX_Imm        = imm;
    ID_EX_ALUSrc     = alusrc;
    ForwardA         = fa;
    ForwardB         = fb;
    WB_WriteData     = wb;
    ID_EX_RegisterRd = rd;
    ID_EX_RegWrite   = rw;
    ID_EX_MemRead    = mr;
    ID_EX_MemWrite   = mw;
    ID_EX_MemtoReg   = m2r;
    Flush            = flush;
  endtask

  task automatic checkOutput(input string tag, input logic exp_stall);
    #1;
    chk({tag, " stall"},     32'(EX_Stall),          32'(exp_stall));
    chk({tag, " result"},    EX_MEM_ALUResult,       exp_result);
    chk({tag, " wdata"},     EX_MEM_WriteData,       exp_wdata);
    chk({tag, " rd"},        32'(EX_MEM_RegisterRd), 32'(exp_rd));
    chk({tag, " regwrite"},  32'(EX_MEM_RegWrite),   32'(exp_rw));
    chk({tag, " memread"},   32'(EX_MEM_MemRead),    32'(exp_mr));
    chk({tag, " memwrite"},  32'(EX_MEM_MemWrite),   32'(exp_mw));
    chk({tag, " memtoreg"},  32'(EX_MEM_MemtoReg),   32'(exp_m2r));
  endtask

  task automatic modelBubble();
    exp_rd  = 5'd0;
    exp_rw  = 1'b0;
    exp_mr  = 1'b0;
    exp_mw  = 1'b0;
    exp_m2r = 1'b0;
  endtask

  task automatic modelLoad(input logic [31:0] res, input logic [31:0] wd);
    exp_result = res;
    exp_wdata  = wd;
    exp_rd     = ID_EX_RegisterRd;
    exp_rw     = ID_EX_RegWrite;
    exp_mr     = ID_EX_MemRead;
    exp_mw     = ID_EX_MemWrite;
    exp_m2r    = ID_EX_MemtoReg;
  endtask

  // One clock of a non-multiply instruction (or a killed/invalid one).
  task automatic stepSingle(input string tag);
    logic [31:0] a, rt, b;
    #1;
    chk({tag, " comb stall"}, 32'(EX_Stall), 32'd0);
    a  = fwd_value(ForwardA, ID_EX_ReadData1, exp_result, WB_WriteData);
    rt = fwd_value(ForwardB, ID_EX_ReadData2, exp_result, WB_WriteData);
    b  = ID_EX_ALUSrc ? ID_EX_Imm : rt;
    tick();
    if (Flush || !ID_EX_Valid) modelBubble();
    else modelLoad(ref_alu(ID_EX_ALUOp, a, b), rt);
    checkOutput(tag, 1'b0);
  endtask

  // Runs a valid MUL already present on the inputs until its product lands.
  task automatic runMul(input string tag, input logic [31:0] wb_change);
    logic [31:0] a, b, rt, prod;
    int stall_cycles;
    a    = fwd_value(ForwardA, ID_EX_ReadData1, exp_result, WB_WriteData);
    b    = ID_EX_ALUSrc ? ID_EX_Imm : fwd_value(ForwardB, ID_EX_ReadData2, exp_result, WB_WriteData);
    prod = ref_alu(ALU_MUL, a, b);
    stall_cycles = 0;
    #1;
    while (EX_Stall === 1'b1 && stall_cycles < 100) begin
      stall_cycles++;
      if (stall_cycles == 10) WB_WriteData = wb_change;
      tick();
      modelBubble();
      chk({tag, " bubble regwrite"}, 32'(EX_MEM_RegWrite), 32'd0);
      chk({tag, " bubble rd"}, 32'(EX_MEM_RegisterRd), 32'd0);
      #1;
    end
    chk({tag, " stall cycles"}, 32'(stall_cycles), 32'(MUL_CYCLES + 1));
    rt = fwd_value(ForwardB, ID_EX_ReadData2, exp_result, WB_WriteData);
    tick();
    modelLoad(prod, rt);
    ID_EX_Valid = 1'b0;
    checkOutput(tag, 1'b0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired before the test completed");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    // valid op a b imm alusrc fa fb wb mw exp_res exp_wd
    vecs[0]  = '{1'b1, ALU_ADD,  32'd2,        32'd3,      32'd0,      1'b0, 2'b00, 2'b00, 32'd0,  1'b0, 32'd5,        32'd3};
    vecs[1]  = '{1'b1, ALU_ADD,  32'd99,       32'd99,     32'd0,      1'b0, 2'b10, 2'b01, 32'd7,  1'b0, 32'd12,       32'd7};
    vecs[2]  = '{1'b1, ALU_ADD,  32'd99,       32'd99,     32'd0,      1'b0, 2'b11, 2'b11, 32'd7,  1'b0, 32'd198,      32'd99};
    vecs[3]  = '{1'b1, ALU_SUB,  32'd0,        32'd1,      32'd0,      1'b0, 2'b00, 2'b00, 32'd0,  1'b0, 32'hFFFFFFFF, 32'd1};
    vecs[4]  = '{1'b1, ALU_SLT,  32'h80000000, 32'd1,      32'd0,      1'b0, 2'b00, 2'b00, 32'd0,  1'b0, 32'd1,        32'd1};
    vecs[5]  = '{1'b1, ALU_SLTU, 32'h80000000, 32'd1,      32'd0,      1'b0, 2'b00, 2'b00, 32'd0,  1'b0, 32'd0,        32'd1};
    vecs[6]  = '{1'b1, ALU_SRA,  32'h80000000, 32'd31,     32'd0,      1'b0, 2'b00, 2'b00, 32'd0,  1'b0, 32'hFFFFFFFF, 32'd31};
    vecs[7]  = '{1'b1, ALU_LUI,  32'd0,        32'hDEAD,   32'h1234,   1'b1, 2'b00, 2'b00, 32'd0,  1'b0, 32'h12340000, 32'hDEAD};
    vecs[8]  = '{1'b1, ALU_SLL,  32'd1,        32'd4,      32'd0,      1'b0, 2'b00, 2'b00, 32'd0,  1'b0, 32'h10,       32'd4};
    vecs[9]  = '{1'b1, ALU_SRL,  32'h80000000, 32'd4,      32'd0,      1'b0, 2'b00, 2'b00, 32'd0,  1'b0, 32'h08000000, 32'd4};
    vecs[10] = '{1'b1, ALU_AND,  32'hF0F0,     32'hFF00,   32'd0,      1'b0, 2'b00, 2'b00, 32'd0,  1'b0, 32'hF000,     32'hFF00};
    vecs[11] = '{1'b1, ALU_OR,   32'hF0F0,     32'hFF00,   32'd0,      1'b0, 2'b00, 2'b00, 32'd0,  1'b0, 32'hFFF0,     32'hFF00};
    vecs[12] = '{1'b1, ALU_XOR,  32'hF0F0,     32'hFF00,   32'd0,      1'b0, 2'b00, 2'b00, 32'd0,  1'b0, 32'h0FF0,     32'hFF00};
    vecs[13] = '{1'b1, ALU_NOR,  32'd0,        32'd0,      32'd0,      1'b0, 2'b00, 2'b00, 32'd0,  1'b0, 32'hFFFFFFFF, 32'd0};
    vecs[14] = '{1'b1, ALU_ADD,  32'd100,      32'd55,     32'd4,      1'b1, 2'b00, 2'b10, 32'd0,  1'b1, 32'd104,      32'hFFFFFFFF};
    vecs[15] = '{1'b0, ALU_ADD,  32'd1,        32'd1,      32'd0,      1'b0, 2'b00, 2'b00, 32'd0,  1'b0, 32'd104,      32'hFFFFFFFF};
    vecs[16] = '{1'b1, 4'hE,     32'd5,        32'd6,      32'd0,      1'b0, 2'b00, 2'b00, 32'd0,  1'b0, 32'd0,        32'd6};
    vecs[17] = '{1'b1, ALU_ADD,  32'd77,       32'h20,     32'd0,      1'b0, 2'b01, 2'b00, 32'h10, 1'b0, 32'h30,       32'h20};

    // Reset state.
    rst_n = 1'b0;
    applyStimulus(1'b0, ALU_ADD, 32'd0, 32'd0, 32'd0, 1'b0, 2'b00, 2'b00, 32'd0, 5'd0,
                  1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    exp_result = 32'd0;
    exp_wdata  = 32'd0;
    modelBubble();
    tick();
    tick();
    checkOutput("reset", 1'b0);
    rst_n = 1'b1;
    tick();

    // Directed ALU / forwarding table.
    for (int i = 0; i < 18; i++) begin
      applyStimulus(vecs[i].valid, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].imm, vecs[i].alusrc,
                    vecs[i].fa, vecs[i].fb, vecs[i].wb, 5'(i + 1), ~vecs[i].mw, 1'b0, vecs[i].mw,
                    1'b0, 1'b0);
      #1;
      chk($sformatf("vec%0d stall", i), 32'(EX_Stall), 32'd0);
      tick();
      chk($sformatf("vec%0d result", i), EX_MEM_ALUResult, vecs[i].exp_res);
      chk($sformatf("vec%0d wdata", i), EX_MEM_WriteData, vecs[i].exp_wd);
      chk($sformatf("vec%0d rd", i), 32'(EX_MEM_RegisterRd), vecs[i].valid ? 32'(i + 1) : 32'd0);
      chk($sformatf("vec%0d regwrite", i), 32'(EX_MEM_RegWrite), 32'(vecs[i].valid & ~vecs[i].mw));
      chk($sformatf("vec%0d memwrite", i), 32'(EX_MEM_MemWrite), 32'(vecs[i].valid & vecs[i].mw));
      exp_result = vecs[i].exp_res;
      exp_wdata  = vecs[i].exp_wd;
      exp_rd     = vecs[i].valid ? 5'(i + 1) : 5'd0;
      exp_rw     = vecs[i].valid & ~vecs[i].mw;
      exp_mr     = 1'b0;
      exp_mw     = vecs[i].valid & vecs[i].mw;
      exp_m2r    = 1'b0;
    end

    // MUL 0xFFFF x 0x10001 with A taken from WB, which changes mid-op.
    applyStimulus(1'b1, ALU_MUL, 32'hDEADBEEF, 32'h10001, 32'd0, 1'b0, 2'b01, 2'b00, 32'hFFFF,
                  5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    runMul("mul", 32'h12345678);
    chk("mul product const", EX_MEM_ALUResult, 32'hFFFFFFFF);
    chk("mul regwrite const", 32'(EX_MEM_RegWrite), 32'd1);

    // Dependent ADD picks up the product through EX/MEM forwarding.
    applyStimulus(1'b1, ALU_ADD, 32'd0, 32'd1, 32'd0, 1'b0, 2'b10, 2'b00, 32'd0, 5'd10,
                  1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    stepSingle("mul dependent");
    chk("mul dependent const", EX_MEM_ALUResult, 32'd0);

    // Flush at BUSY cycle 10.
    applyStimulus(1'b1, ALU_MUL, 32'd3, 32'd5, 32'd0, 1'b0, 2'b00, 2'b00, 32'd0, 5'd11,
                  1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 10; k++) begin
      #1;
      chk("flush pre stall", 32'(EX_Stall), 32'd1);
      tick();
      modelBubble();
    end
    Flush = 1'b1;
    #1;
    chk("flush comb stall", 32'(EX_Stall), 32'd0);
    tick();
    modelBubble();
    applyStimulus(1'b1, ALU_ADD, 32'd40, 32'd2, 32'd0, 1'b0, 2'b00, 2'b00, 32'd0, 5'd12,
                  1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("flush bubble", 1'b0);
    stepSingle("post flush add");
    chk("post flush add const", EX_MEM_ALUResult, 32'd42);

    // Reset pulse at BUSY cycle 5.
    applyStimulus(1'b1, ALU_MUL, 32'd7, 32'd9, 32'd0, 1'b0, 2'b00, 2'b00, 32'd0, 5'd13,
                  1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) tick();
    rst_n = 1'b0;
    exp_result = 32'd0;
    exp_wdata  = 32'd0;
    modelBubble();
    checkOutput("mid-mul reset", 1'b0);
    ID_EX_Valid = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 40; k++) begin
      tick();
      checkOutput("post reset idle", 1'b0);
    end
    applyStimulus(1'b1, ALU_MUL, 32'd1000, 32'd0, 32'd3000, 1'b1, 2'b00, 2'b00, 32'd0, 5'd14,
                  1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    runMul("restart mul", 32'hCAFEF00D);
    chk("restart mul const", EX_MEM_ALUResult, 32'd3000000);

    // Random instructions against the reference model.
    for (int i = 0; i < 300; i++) begin
      logic [3:0] op;
      logic       valid, flush;
      op    = 4'($urandom_range(0, 15));
      valid = ($urandom_range(0, 9) != 0);
      flush = ($urandom_range(0, 19) == 0);
      applyStimulus(valid, op, $urandom, $urandom, $urandom, 1'($urandom), 2'($urandom),
                    2'($urandom), $urandom, 5'($urandom), 1'($urandom), 1'($urandom),
                    1'($urandom), 1'($urandom), flush);
      if (valid && !flush && op == ALU_MUL) runMul("rand mul", $urandom);
      else stepSingle("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
